// File: rtl/sprite_mover.sv
// Frame-synchronous sprite origin controller: moves the sprite once per frame at the
// vsync falling edge, either bouncing off the screen edges or following the buttons.
module sprite_mover #(
  parameter int SCREEN_W = 1024,
  parameter int SCREEN_H = 768,
  parameter int WIDTH    = 128,
  parameter int HEIGHT   = 256,
  parameter int X_INIT   = 448,
  parameter int Y_INIT   = 256
) (
  input  logic        pixel_clk,
  input  logic        reset,
  input  logic        vsync,
  input  logic        enable,
  input  logic        auto_mode,
  input  logic [3:0]  speed,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic        frame_tick,
  output logic        bounce_x,
  output logic        bounce_y
);

  localparam logic signed [11:0] XMAX_S = 12'(SCREEN_W - WIDTH);
  localparam logic signed [10:0] YMAX_S = 11'(SCREEN_H - HEIGHT);
  localparam logic [10:0]        X_RST  = 11'(X_INIT);
  localparam logic [9:0]         Y_RST  = 10'(Y_INIT);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CALC, S_APPLY} state_t;

  state_t             r_state, w_state_next;
  logic               r_vsync_d, r_frame_tick;
  logic [10:0]        r_x, w_nx;
  logic [9:0]         r_y, w_ny;
  logic               r_dir_x, r_dir_y, w_dir_x, w_dir_y;
  logic               r_bounce_x, r_bounce_y, w_bx, w_by;
  logic signed [11:0] w_cx;
  logic signed [10:0] w_cy;

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (enable) w_state_next = S_WAIT;
      S_WAIT:  if (!enable) w_state_next = S_IDLE;
               else if (r_frame_tick) w_state_next = S_CALC;
      S_CALC:  w_state_next = S_APPLY;
      S_APPLY: w_state_next = S_WAIT;
      default: w_state_next = S_IDLE;
    endcase
  end

  // X axis: 12-bit signed candidate so overshoot past either wall is visible.
  always_comb begin
    w_nx    = r_x;
    w_dir_x = r_dir_x;
    w_bx    = 1'b0;
    w_cx    = '0;
    if (speed != 4'd0) begin
      if (auto_mode) begin
        if (r_dir_x) begin
          w_cx = $signed({1'b0, r_x}) + $signed({8'b0, speed});
          if (w_cx >= XMAX_S) begin
            w_nx = XMAX_S[10:0]; w_dir_x = 1'b0; w_bx = 1'b1;
          end else w_nx = w_cx[10:0];
        end else begin
          w_cx = $signed({1'b0, r_x}) - $signed({8'b0, speed});
          if (w_cx <= 12'sd0) begin
            w_nx = '0; w_dir_x = 1'b1; w_bx = 1'b1;
          end else w_nx = w_cx[10:0];
        end
      end else if (btn_right && !btn_left) begin
        w_cx = $signed({1'b0, r_x}) + $signed({8'b0, speed});
        w_nx = (w_cx > XMAX_S) ? XMAX_S[10:0] : w_cx[10:0];
      end else if (btn_left && !btn_right) begin
        w_cx = $signed({1'b0, r_x}) - $signed({8'b0, speed});
        w_nx = (w_cx < 12'sd0) ? 11'd0 : w_cx[10:0];
      end
    end
  end

  // Y axis: same rules on an 11-bit signed candidate; up is the negative direction.
  always_comb begin
    w_ny    = r_y;
    w_dir_y = r_dir_y;
    w_by    = 1'b0;
    w_cy    = '0;
    if (speed != 4'd0) begin
      if (auto_mode) begin
        if (r_dir_y) begin
          w_cy = $signed({1'b0, r_y}) + $signed({7'b0, speed});
          if (w_cy >= YMAX_S) begin
            w_ny = YMAX_S[9:0]; w_dir_y = 1'b0; w_by = 1'b1;
          end else w_ny = w_cy[9:0];
        end else begin
          w_cy = $signed({1'b0, r_y}) - $signed({7'b0, speed});
          if (w_cy <= 11'sd0) begin
            w_ny = '0; w_dir_y = 1'b1; w_by = 1'b1;
          end else w_ny = w_cy[9:0];
        end
      end else if (btn_down && !btn_up) begin
        w_cy = $signed({1'b0, r_y}) + $signed({7'b0, speed});
        w_ny = (w_cy > YMAX_S) ? YMAX_S[9:0] : w_cy[9:0];
      end else if (btn_up && !btn_down) begin
        w_cy = $signed({1'b0, r_y}) - $signed({7'b0, speed});
        w_ny = (w_cy < 11'sd0) ? 10'd0 : w_cy[9:0];
      end
    end
  end

  always_ff @(posedge pixel_clk) begin
    // NOTE: state registers use non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    if (reset) begin
      r_state      <= S_IDLE;
      r_vsync_d    <= 1'b0;
      r_frame_tick <= 1'b0;
      r_x          <= X_RST;
      r_y          <= Y_RST;
      r_dir_x      <= 1'b1;
      r_dir_y      <= 1'b1;
      r_bounce_x   <= 1'b0;
      r_bounce_y   <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_vsync_d    <= vsync;
      r_frame_tick <= r_vsync_d & ~vsync;
      r_bounce_x   <= 1'b0;
      r_bounce_y   <= 1'b0;
      // Results computed in CALC land on the edge into APPLY, so APPLY is the
      // cycle where the new origin first shows and the bounce pulses are high.
      if (r_state == S_CALC) begin
        r_x        <= w_nx;
        r_y        <= w_ny;
        r_dir_x    <= w_dir_x;
        r_dir_y    <= w_dir_y;
        r_bounce_x <= w_bx;
        r_bounce_y <= w_by;
      end
    end
  end

  assign x          = r_x;
  assign y          = r_y;
  assign frame_tick = r_frame_tick;
  assign bounce_x   = r_bounce_x;
  assign bounce_y   = r_bounce_y;

endmodule

// File: tb/tb_sprite_mover.sv
// Directed bench for sprite_mover: walks the sprite to each wall with manual moves,
// then checks auto bounces, tick discipline and reset inside the APPLY cycle.
module tb_sprite_mover;

  logic        clk = 1'b0;
  logic        reset, vsync, enable, auto_mode;
  logic [3:0]  speed;
  logic        btn_up, btn_down, btn_left, btn_right;
  logic [10:0] x;
  logic [9:0]  y;
  logic        frame_tick, bounce_x, bounce_y;

  int n_checks = 0;
  int n_errors = 0;

  logic        obs_ft1, obs_ft2, obs_bx, obs_by, obs_after;
  logic [10:0] obs_x;
  logic [9:0]  obs_y;
  int          tick_count;

  always #5 clk = ~clk;

  sprite_mover dut (
    .pixel_clk (clk),
    .reset     (reset),
    .vsync     (vsync),
    .enable    (enable),
    .auto_mode (auto_mode),
    .speed     (speed),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .x         (x),
    .y         (y),
    .frame_tick(frame_tick),
    .bounce_x  (bounce_x),
    .bounce_y  (bounce_y)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One vsync fall; samples the tick in its two cycles and the origin/pulses in APPLY.
  task automatic frame();
    vsync = 1'b0;
    cyc(); obs_ft1 = frame_tick;
    cyc(); obs_ft2 = frame_tick;
    cyc(); obs_x = x; obs_y = y; obs_bx = bounce_x; obs_by = bounce_y;
    vsync = 1'b1;
    cyc(); obs_after = bounce_x | bounce_y;
  endtask

  task automatic set_btn(input logic u, input logic d, input logic l, input logic r);
    btn_up = u; btn_down = d; btn_left = l; btn_right = r;
  endtask

  initial begin
    reset = 1'b1; vsync = 1'b1; enable = 1'b0; auto_mode = 1'b0; speed = 4'd0;
    set_btn(0, 0, 0, 0);
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    check("rst_x", 32'(x), 448);
    check("rst_y", 32'(y), 256);
    check("rst_tick", 32'(frame_tick), 0);
    check("rst_bx", 32'(bounce_x), 0);
    check("rst_by", 32'(bounce_y), 0);

    // Disabled: ticks still pulse, origin frozen.
    frame();
    check("dis_tick", 32'(obs_ft1), 1);
    frame(); frame();
    check("dis_x", 32'(x), 448);
    check("dis_y", 32'(y), 256);

    // First auto move.
    enable = 1'b1; auto_mode = 1'b1; speed = 4'd4;
    cyc(); cyc();
    frame();
    check("auto_tick_hi", 32'(obs_ft1), 1);
    check("auto_tick_lo", 32'(obs_ft2), 0);
    check("auto_x", 32'(obs_x), 452);
    check("auto_y", 32'(obs_y), 260);
    check("auto_nobounce", 32'({obs_bx, obs_by}), 0);

    // Manual: opposing x buttons cancel, down moves y.
    auto_mode = 1'b0; speed = 4'd3; set_btn(0, 1, 1, 1);
    frame();
    check("man_both_x", 32'(obs_x), 452);
    check("man_down_y", 32'(obs_y), 263);

    // Walk left to x=2, then clamp at 0 without a bounce.
    speed = 4'd15; set_btn(0, 0, 1, 0);
    for (int i = 0; i < 30; i++) frame();
    check("man_left_x", 32'(x), 2);
    speed = 4'd3;
    frame();
    check("man_clamp_x", 32'(obs_x), 0);
    check("man_clamp_nobx", 32'(obs_bx), 0);
    check("man_clamp_y", 32'(obs_y), 263);

    // Walk down to 503, then auto lands on the bottom wall.
    speed = 4'd15; set_btn(0, 1, 0, 0);
    for (int i = 0; i < 16; i++) frame();
    check("man_down2_y", 32'(y), 503);
    auto_mode = 1'b1; speed = 4'd9; set_btn(0, 0, 0, 0);
    frame();
    check("bot_y", 32'(obs_y), 512);
    check("bot_by", 32'(obs_by), 1);
    check("bot_x", 32'(obs_x), 9);
    check("bot_bx", 32'(obs_bx), 0);

    // speed 0 in auto: nothing moves, nothing pulses.
    speed = 4'd0;
    frame();
    check("spd0_xy", 32'({obs_x, obs_y}), 32'({11'd9, 10'd512}));
    check("spd0_nob", 32'({obs_bx, obs_by}), 0);

    // Walk up to y=4 with dir_y still negative, then hit the top exactly.
    auto_mode = 1'b0; speed = 4'd15; set_btn(1, 0, 0, 0);
    for (int i = 0; i < 33; i++) frame();
    speed = 4'd13;
    frame();
    check("man_up_y", 32'(y), 4);
    auto_mode = 1'b1; speed = 4'd4; set_btn(0, 0, 0, 0);
    frame();
    check("top_y", 32'(obs_y), 0);
    check("top_by", 32'(obs_by), 1);
    check("top_x", 32'(obs_x), 13);
    frame();
    check("top_rebound_y", 32'(obs_y), 4);
    check("top_rebound_by", 32'(obs_by), 0);
    check("top_rebound_x", 32'(obs_x), 17);

    // Walk right to 894, then auto overshoots the right wall.
    auto_mode = 1'b0; speed = 4'd15; set_btn(0, 0, 0, 1);
    for (int i = 0; i < 58; i++) frame();
    speed = 4'd7;
    frame();
    check("man_right_x", 32'(x), 894);
    auto_mode = 1'b1; speed = 4'd5; set_btn(0, 0, 0, 0);
    frame();
    check("right_x", 32'(obs_x), 896);
    check("right_bx", 32'(obs_bx), 1);
    check("right_by", 32'(obs_by), 0);
    check("right_y", 32'(obs_y), 9);
    check("right_pulse_len", 32'(obs_after), 0);
    frame();
    check("right_rebound_x", 32'(obs_x), 891);
    check("right_rebound_y", 32'(obs_y), 14);

    // vsync held low for 50 cycles: one tick, one update.
    tick_count = 0;
    vsync = 1'b0;
    for (int i = 0; i < 50; i++) begin
      cyc();
      if (frame_tick) tick_count++;
    end
    vsync = 1'b1;
    cyc(); cyc();
    check("hold_ticks", 32'(tick_count), 1);
    check("hold_x", 32'(x), 886);
    check("hold_y", 32'(y), 19);

    // Reset sampled at the end of the APPLY cycle.
    vsync = 1'b0;
    cyc(); cyc(); cyc();
    check("apply_x", 32'(x), 881);
    reset = 1'b1;
    cyc();
    reset = 1'b0; vsync = 1'b1;
    check("mid_rst_x", 32'(x), 448);
    check("mid_rst_y", 32'(y), 256);
    check("mid_rst_nob", 32'({bounce_x, bounce_y, frame_tick}), 0);
    cyc();
    frame();
    check("post_rst_x", 32'(obs_x), 453);
    check("post_rst_y", 32'(obs_y), 261);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
